// File: rtl/mult_pipe.sv
// Fully pipelined RV32M multiply unit: one op per cycle, STAGES-cycle latency,
// per-op branch masks for selective speculative kill, valid/ready result port.
module mult_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 12,
  parameter int BR_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [BR_W-1:0]  in_brmask,
  input  logic             flush,
  input  logic [BR_W-1:0]  flush_mask,
  input  logic             resolve_valid,
  input  logic [BR_W-1:0]  resolve_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [BR_W-1:0]  out_brmask
);
  // Only the low 2*XLEN bits of the 2*XLEN+2-bit signed product are ever selected.
  localparam int RW = 2 * XLEN;

  logic                 vld_p [1:STAGES];
  logic [1:0]           op_p  [1:STAGES];
  logic [TAG_W-1:0]     tag_p [1:STAGES];
  logic [BR_W-1:0]      bm_p  [1:STAGES];
  logic signed [RW-1:0] prod_out;
  logic                 advance;

  // rs1 is unsigned only for mulhu (op 11).
  function automatic logic signed [XLEN:0] ext_a(input logic [1:0] op, input logic [XLEN-1:0] a);
    return (op == 2'b11) ? {1'b0, a} : {a[XLEN-1], a};
  endfunction

  // rs2 is unsigned for mulhsu and mulhu (op 1x).
  function automatic logic signed [XLEN:0] ext_b(input logic [1:0] op, input logic [XLEN-1:0] b);
    return op[1] ? {1'b0, b} : {b[XLEN-1], b};
  endfunction

  function automatic logic signed [RW-1:0] widen(input logic signed [XLEN:0] x);
    return {{(RW-XLEN-1){x[XLEN]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] sel_result(input logic [1:0] op, input logic signed [RW-1:0] prod);
    return (op == 2'b00) ? prod[XLEN-1:0] : prod[RW-1:XLEN];
  endfunction

  function automatic logic hit(input logic [BR_W-1:0] bm, input logic fl, input logic [BR_W-1:0] fm);
    return fl && (|(bm & fm));
  endfunction

  function automatic logic [BR_W-1:0] clr(input logic [BR_W-1:0] bm, input logic rv, input logic [BR_W-1:0] rm);
    return rv ? (bm & ~rm) : bm;
  endfunction

  assign advance  = !vld_p[STAGES] || out_ready;
  assign in_ready = advance;

  // Control: kill uses pre-resolve masks; holding stages are still killed and resolved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= STAGES; i++) begin
        vld_p[i] <= 1'b0;
        op_p[i]  <= '0;
        tag_p[i] <= '0;
        bm_p[i]  <= '0;
      end
    end else if (advance) begin
      // input -> p1
      vld_p[1] <= in_valid && !hit(in_brmask, flush, flush_mask);
      bm_p[1]  <= clr(in_brmask, resolve_valid, resolve_mask);
      op_p[1]  <= in_op;
      tag_p[1] <= in_tag;
      // p(i-1) -> p(i)
      for (int i = 2; i <= STAGES; i++) begin
        vld_p[i] <= vld_p[i-1] && !hit(bm_p[i-1], flush, flush_mask);
        bm_p[i]  <= clr(bm_p[i-1], resolve_valid, resolve_mask);
        op_p[i]  <= op_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end else begin
      for (int i = 1; i <= STAGES; i++) begin
        vld_p[i] <= vld_p[i] && !hit(bm_p[i], flush, flush_mask);
        bm_p[i]  <= clr(bm_p[i], resolve_valid, resolve_mask);
      end
    end
  end

  if (STAGES == 1) begin : g_single
    logic signed [RW-1:0] prod_r;

    // input -> p1: product formed at the input and registered as the output
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_r <= '0;
      end else if (advance) begin
        prod_r <= widen(ext_a(in_op, in_a)) * widen(ext_b(in_op, in_b));
      end
    end

    assign prod_out = prod_r;
  end else begin : g_multi
    logic signed [XLEN:0]   a_p1;
    logic signed [XLEN:0]   b_p1;
    logic signed [RW-1:0]   prod_p [2:STAGES];

    // input -> p1: extended operands
    always_ff @(posedge clk) begin
      if (advance) begin
        a_p1 <= ext_a(in_op, in_a);
        b_p1 <= ext_b(in_op, in_b);
      end
    end

    // p1 -> p2: multiply; later stages only carry the product so it can be retimed
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 2; i <= STAGES; i++) prod_p[i] <= '0;
      end else if (advance) begin
        prod_p[2] <= widen(a_p1) * widen(b_p1);
        for (int i = 3; i <= STAGES; i++) prod_p[i] <= prod_p[i-1];
      end
    end

    assign prod_out = prod_p[STAGES];
  end

  assign out_valid  = vld_p[STAGES] && !hit(bm_p[STAGES], flush, flush_mask);
  assign out_brmask = clr(bm_p[STAGES], resolve_valid, resolve_mask);
  assign out_tag    = tag_p[STAGES];
  assign out_result = sel_result(op_p[STAGES], prod_out);

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Fully pipelined, parametrised RV32M multiply functional unit that issues from the multiply reservation station and broadcasts on the CDB. It accepts one operation per cycle, with STAGES-cycle latency. It replaces the single-in-flight sequential multiplier with per-op branch masks for selective speculative flush, and it applies CDB backpressure through a valid/ready output.

## Interface
- XLEN, 32: operand/result width.
- STAGES, 3: pipeline depth (≥1); also the accept-to-output latency.
- TAG_W, 12: opaque tag width ({rob_idx, pd_idx}), carried unmodified.
- BR_W, 4: branch-mask width (one bit per in-flight unresolved branch, EBR_NUM).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  RS presents an op.
- in_ready  out  1  unit accepts this cycle.
- in_op  in  2  funct3[1:0]: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu.
- in_a, in_b  in  XLEN  rs1/rs2 values.
- in_tag  in  TAG_W  destination tag.
- in_brmask  in  BR_W  branches this op depends on.
- flush  in  1  mispredict recovery.
- flush_mask  in  BR_W  one-hot mispredicted branch.
- resolve_valid  in  1  branch resolved correctly.
- resolve_mask  in  BR_W  one-hot resolved branch.
- out_valid  out  1  result on CDB.
- out_ready  in  1  CDB grant.
- out_result  out  XLEN  product slice.
- out_tag  out  TAG_W  tag of result.
- out_brmask  out  BR_W  current mask of result.

## Operation
- Per-stage state: valid, op, tag, brmask, payload (operands or product). The last stage is the output register.
- Operand extension to XLEN+1 bits: a is sign-extended for mul/mulh/mulhsu and zero-extended for mulhu. b is sign-extended for mul/mulh and zero-extended for mulhsu/mulhu. The product is a 2·XLEN+2-bit signed value.
- Result: mul → product[XLEN-1:0]; others → product[2·XLEN-1:XLEN].
- The product is formed from the stage-1 registered operands. Stages 2..STAGES carry it, for retiming. With STAGES=1, the product is formed at input and registered into the output.
- advance = !v[STAGES] || out_ready. All stages shift together when advance=1 and hold otherwise.
- in_ready = advance. An op is accepted on in_valid && in_ready.
- Kill: any op (in flight or being accepted) with (brmask & flush_mask) != 0 while flush=1 has its valid bit cleared at the next edge. This applies even to stages that are holding. Unaffected ops proceed normally.
- Resolve: resolve_valid clears the resolve_mask bits in every stage's brmask and in the incoming in_brmask before capture.
- Flush and resolve in the same cycle: the kill test uses pre-clear masks.
- out_valid = v[STAGES] && !(flush && |(brmask[STAGES] & flush_mask)). A killed result is never seen as valid.
- out_brmask shows the mask after same-cycle resolve clearing (combinational).
- Ops retire in issue order. There are no bubbles except those from flush or from in_valid=0.

## Timing
- Reset (async assert, sync-released use): all valid bits 0, so out_valid=0 and in_ready=1. out_result, out_tag, and out_brmask are 0.
- Latency: op accepted at edge k appears with out_valid=1 in the cycle after edge k+STAGES-1 (i.e., STAGES edges after issue), if no stall.
- Throughput: 1 op/cycle while out_ready=1.
- Stall: out_valid && !out_ready freezes the whole pipe. in_ready drops combinationally the same cycle. out_result/out_tag remain stable until the transfer.
- Capacity: STAGES ops max in flight.
- Reset mid-operation: all in-flight ops are discarded immediately. No output is produced.

## Test plan
- mul 7 × 0xFFFFFFFD, then mulh 0x80000000 × 0x80000000, then mulhsu 0xFFFFFFFF × 0xFFFFFFFF, then mulhu 0xFFFFFFFF × 0xFFFFFFFF, issued back-to-back with STAGES=3 -> results 0xFFFFFFEB, 0x40000000, 0xFFFFFFFF, 0xFFFFFFFE on four consecutive cycles, starting 3 cycles after the first accept, tags in order.
- Stream 10 ops, out_ready=0 for cycles 5-8 -> in_ready low those cycles, no result lost or duplicated, order preserved, out_result stable during stall.
- Ops with brmask 0001, 0010, 0000 in flight; flush with flush_mask=0001 -> only the first is dropped; the other two appear with unchanged latency. A concurrent input with in_brmask 0001 is not accepted into the pipe.
- resolve_mask=0010 on an in-flight op with mask 0110 -> out_brmask=0100. A later flush 0010 does not kill it.
- Flush of the op in the output register during a stall -> out_valid=0 that cycle and afterward. The next op advances.
- rst_n pulsed low with 3 ops in flight -> out_valid=0 immediately, in_ready=1, no stale result after release. Repeat the test with STAGES=1 and STAGES=5.
